rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares one single-port image ROM (registered read, palette index out) between N_REQ pixel fetchers: background layer, sprite layers, overlay.
- Round-robin arbitration, at most one ROM read issued per vga_clk cycle.
- Returns each read's data to its originating requester with a one-hot valid and fixed latency.
- Sits between the per-layer address generators and the ROM/palette pair in the VGA pixel path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 19, ROM address width.
- DATA_W, 4, ROM data (palette index) width.
- ROM_LAT, 1, vga_clk edges from rom_addr change to valid rom_q (1..4).

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when 0 no new grants are issued; in-flight reads still complete.
- req  in  N_REQ  per-requester read request, held until granted.
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- gnt  out  N_REQ  one-hot grant, combinational.
- rom_addr  out  ADDR_W  registered address to ROM.
- rom_q  in  DATA_W  ROM read data.
- rd_data  out  DATA_W  registered returned data.
- rd_valid  out  N_REQ  one-hot, marks the owner of rd_data for one cycle.
- pending  out  1  high while any read is in flight.

Behaviour:
- Reset (async assert, sync release): rom_addr=0, rd_data=0, rd_valid=0, pending=0, tag pipeline cleared, rr pointer=N_REQ-1 (requester 0 wins first). gnt=0 while reset_n=0.
- Grant:
  - gnt = one-hot of the first i with req[i]=1, searching from (ptr+1) mod N_REQ upward with wrap.
  - gnt=0 when enable=0 or no req.
- Transfer at a posedge where gnt[i]=1:
  - rom_addr <= req_addr[i]; ptr <= i; tag[0] <= onehot(i).
  - Requester drops or changes req/addr after the edge.
- No transfer: rom_addr and ptr hold; tag[0] <= 0.
- Tag pipeline is ROM_LAT+1 stages deep and shifts every cycle.
- Return timing: for a transfer at edge T, rd_data <= rom_q and rd_valid <= tag at edge T+ROM_LAT+1. rd_valid[i] is high for exactly one cycle.
  - Example: ROM_LAT=1, transfer at edge 0 → rd_valid visible after edge 2.
- No return in a cycle: rd_valid=0, rd_data holds its last value.
- Throughput: back-to-back transfers every cycle. With k requesters continuously requesting, each is granted exactly once per k cycles.
- pending = OR of all tag stages.
- enable falling mid-burst: already-transferred reads return normally; no new gnt.
- reset_n asserted mid-flight: all in-flight reads are discarded; no rd_valid after release.
- req[i] dropped before grant: no transfer, no error; ptr unchanged.
- Single requester continuously requesting: granted every cycle.

Optional Feature:
- Macro: ARB_PRIO0_EN.
- Defined: requester 0 (background) has fixed highest priority. Whenever req[0]=1 and enable=1, gnt=0b...01 regardless of ptr, and ptr is not updated by a requester-0 grant. Requesters 1..N_REQ-1 round-robin among themselves when req[0]=0.
- Undefined: requester 0 participates in plain round-robin like the others.

Test Plan:
- Reset, then req=4'b0001, addr0=0x00123, ROM model returns addr[3:0] → gnt=0001 at first edge; rd_valid=0001, rd_data=0x3 exactly ROM_LAT+1 edges later; pending high for ROM_LAT+1 cycles.
- req=4'b1111 held 8 cycles, distinct addresses → grant order 0,1,2,3,0,1,2,3; rd_valid sequence matches with lag ROM_LAT+1; no gaps.
- req=4'b1010 continuously → grants alternate 1,3,1,3; gnt[0] and gnt[2] never asserted.
- enable dropped after 2 grants of a 4-req burst → exactly 2 rd_valid pulses follow, then gnt=0 and pending falls.
- reset_n pulsed low one cycle after a transfer → rd_valid stays 0, rom_addr=0, next grant goes to the lowest-index requester.
- ARB_PRIO0_EN defined, req=4'b0111 for 4 cycles → gnt=0001 every cycle; after req[0] drops → grants 1,2,1,2.

Source files
------------

// File: rtl/rom_read_arbiter_if.sv
// Bus between the per-layer pixel fetchers, the shared image ROM and the read arbiter.
// master: fetchers + ROM side; slave: rom_read_arbiter.
interface rom_read_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 4
);
  logic                       enable;
  logic [N_REQ-1:0]           req;
  logic [N_REQ*ADDR_W-1:0]    req_addr;
  logic [N_REQ-1:0]           gnt;
  logic [ADDR_W-1:0]          rom_addr;
  logic [DATA_W-1:0]          rom_q;
  logic [DATA_W-1:0]          rd_data;
  logic [N_REQ-1:0]           rd_valid;
  logic                       pending;

  modport master (
    output enable, req, req_addr, rom_q,
    input  gnt, rom_addr, rd_data, rd_valid, pending
  );

  modport slave (
    input  enable, req, req_addr, rom_q,
    output gnt, rom_addr, rd_data, rd_valid, pending
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one registered-read image ROM between N_REQ pixel fetchers.
// Optional macro ARB_PRIO0_EN gives requester 0 (background) fixed highest priority.
module rom_read_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  rom_read_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef ARB_PRIO0_EN
  localparam bit Prio0 = 1'b1;
`else
  localparam bit Prio0 = 1'b0;
`endif

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  gnt_idx, cand_idx;
  logic              gnt_any;
  logic [N_REQ-1:0]  gnt_oh;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [N_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [N_REQ-1:0]  tag_q [ROM_LAT+1];
  logic [N_REQ-1:0]  tag_d [ROM_LAT+1];
  logic              pending;

  // Search starts just past the last winner and wraps; requester 0 may pre-empt.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    if (reset_n && bus.enable) begin
      if (Prio0 && bus.req[0]) begin
        gnt_any = 1'b1;
        gnt_idx = '0;
      end
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        cand_idx = PTR_W'((32'(ptr_q) + k) % N_REQ);
        if (!gnt_any && bus.req[cand_idx] && !(Prio0 && cand_idx == '0)) begin
          gnt_any = 1'b1;
          gnt_idx = cand_idx;
        end
      end
    end
    gnt_oh = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    if (gnt_any) begin
      rom_addr_d = bus.req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
      // A fixed-priority background grant must not disturb the rotation of the others.
      if (!(Prio0 && gnt_idx == '0)) ptr_d = gnt_idx;
    end
    tag_d[0] = gnt_oh;
    for (int unsigned s = 1; s <= ROM_LAT; s++) tag_d[s] = tag_q[s-1];
    rd_valid_d = tag_q[ROM_LAT];
    rd_data_d  = (|tag_q[ROM_LAT]) ? bus.rom_q : rd_data_q;
    pending    = 1'b0;
    for (int unsigned s = 0; s <= ROM_LAT; s++) pending = pending | (|tag_q[s]);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= PTR_W'(N_REQ - 1);
      rom_addr_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      for (int unsigned s = 0; s <= ROM_LAT; s++) tag_q[s] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      for (int unsigned s = 0; s <= ROM_LAT; s++) tag_q[s] <= tag_d[s];
    end
  end

  assign bus.gnt      = gnt_oh;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.pending  = pending;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed self-checking bench for rom_read_arbiter (N_REQ=4, ROM_LAT=1).
// ROM model returns addr[3:0] one edge after rom_addr changes.
module tb_rom_read_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rom_read_arbiter_if #(.N_REQ(4), .ADDR_W(19), .DATA_W(4)) bus ();

  rom_read_arbiter #(.N_REQ(4), .ADDR_W(19), .DATA_W(4), .ROM_LAT(1)) dut (
    .vga_clk (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_q <= bus.rom_addr[3:0];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [18:0] a);
    bus.req_addr[i*19 +: 19] = a;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.enable = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    bus.enable = 1'b1;
    bus.req    = 4'b1111;
    #1;
    n_checks++;
    if (bus.gnt !== 4'b0000) begin
      n_fail++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt);
    end
    n_checks++;
    if (bus.rom_addr !== 19'h0) begin
      n_fail++; $display("FAIL reset_rom_addr: got %h expected 0", bus.rom_addr);
    end
    n_checks++;
    if (bus.rd_valid !== 4'b0000 || bus.rd_data !== 4'h0 || bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h pending=%b expected 0000/0/0",
               bus.rd_valid, bus.rd_data, bus.pending);
    end
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: got gnt=%b pending=%b expected 0000/0", bus.gnt, bus.pending);
    end
    bus.req = '0;
    rst_n   = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    set_addr(0, 19'h00123);
    bus.req = 4'b0001;
    #1;
    n_checks++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++; $display("FAIL single_gnt: got %b expected 0001", bus.gnt);
    end
    tick();
    bus.req = '0;
    n_checks++;
    if (bus.rom_addr !== 19'h00123 || bus.pending !== 1'b1 || bus.rd_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_edge0: got addr=%h pending=%b valid=%b expected 00123/1/0000",
               bus.rom_addr, bus.pending, bus.rd_valid);
    end
    tick();
    n_checks++;
    if (bus.pending !== 1'b1 || bus.rd_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_edge1: got pending=%b valid=%b expected 1/0000",
               bus.pending, bus.rd_valid);
    end
    tick();
    n_checks++;
    if (bus.rd_valid !== 4'b0001 || bus.rd_data !== 4'h3 || bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL single_return: got valid=%b data=%h pending=%b expected 0001/3/0",
               bus.rd_valid, bus.rd_data, bus.pending);
    end
    tick();
    n_checks++;
    if (bus.rd_valid !== 4'b0000 || bus.rd_data !== 4'h3) begin
      n_fail++;
      $display("FAIL single_after: got valid=%b data=%h expected 0000/3 (held)",
               bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_gnt, exp_val, exp_dat;
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 19'h55500 | 19'(i + 9));
    for (int c = 0; c < 10; c++) begin
      bus.req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_gnt = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      n_checks++;
      if (bus.gnt !== exp_gnt) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, bus.gnt, exp_gnt);
      end
      tick();
      exp_val = (c >= 2) ? (4'b0001 << ((c - 2) % 4)) : 4'b0000;
      exp_dat = 4'(9 + (c - 2) % 4);
      n_checks++;
      if (bus.rd_valid !== exp_val || (c >= 2 && bus.rd_data !== exp_dat)) begin
        n_fail++;
        $display("FAIL rr_ret[%0d]: got valid=%b data=%h expected %b/%h",
                 c, bus.rd_valid, bus.rd_data, exp_val, exp_dat);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_alternate;
    logic [3:0] exp_gnt;
    do_reset();
    set_addr(1, 19'h00011);
    set_addr(3, 19'h00033);
    bus.req = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_gnt = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      n_checks++;
      if (bus.gnt !== exp_gnt) begin
        n_fail++; $display("FAIL alt_gnt[%0d]: got %b expected %b", c, bus.gnt, exp_gnt);
      end
      tick();
    end
    bus.req = '0;
  endtask

  task automatic test_enable_drop;
    logic [3:0] exp_gnt, exp_val;
    logic       exp_pend;
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 19'(i + 4));
    bus.req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      bus.enable = (c < 2);
      #1;
      exp_gnt = (c < 2) ? (4'b0001 << c) : 4'b0000;
      n_checks++;
      if (bus.gnt !== exp_gnt) begin
        n_fail++; $display("FAIL en_gnt[%0d]: got %b expected %b", c, bus.gnt, exp_gnt);
      end
      tick();
      exp_val  = (c == 2) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
      exp_pend = (c <= 2);
      n_checks++;
      if (bus.rd_valid !== exp_val || bus.pending !== exp_pend) begin
        n_fail++;
        $display("FAIL en_ret[%0d]: got valid=%b pending=%b expected %b/%b",
                 c, bus.rd_valid, bus.pending, exp_val, exp_pend);
      end
    end
    bus.req    = '0;
    bus.enable = 1'b1;
  endtask

  task automatic test_reset_midflight;
    do_reset();
    set_addr(2, 19'h00007);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rom_addr !== 19'h0 || bus.pending !== 1'b0 || bus.rd_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset: got addr=%h pending=%b valid=%b expected 0/0/0000",
               bus.rom_addr, bus.pending, bus.rd_valid);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (bus.rd_valid !== 4'b0000) begin
        n_fail++; $display("FAIL mid_noret[%0d]: got %b expected 0000", c, bus.rd_valid);
      end
    end
    bus.req = 4'b1111;
    #1;
    n_checks++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++; $display("FAIL mid_first_gnt: got %b expected 0001", bus.gnt);
    end
    bus.req = '0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      set_addr(2, 19'h2a000 | 19'(c + 1));
      #1;
      n_checks++;
      if (bus.gnt !== 4'b0100) begin
        n_fail++; $display("FAIL b2b_gnt[%0d]: got %b expected 0100", c, bus.gnt);
      end
      tick();
      if (c >= 2) begin
        n_checks++;
        if (bus.rd_valid !== 4'b0100 || bus.rd_data !== 4'(c - 1)) begin
          n_fail++;
          $display("FAIL b2b_ret[%0d]: got valid=%b data=%h expected 0100/%h",
                   c, bus.rd_valid, bus.rd_data, 4'(c - 1));
        end
      end
    end
    bus.req = '0;
  endtask

`ifdef ARB_PRIO0_EN
  task automatic test_prio0;
    logic [3:0] exp_gnt;
    do_reset();
    bus.req = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (bus.gnt !== 4'b0001) begin
        n_fail++; $display("FAIL prio_gnt[%0d]: got %b expected 0001", c, bus.gnt);
      end
      tick();
    end
    bus.req = 4'b0110;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_gnt = (c % 2 == 0) ? 4'b0010 : 4'b0100;
      n_checks++;
      if (bus.gnt !== exp_gnt) begin
        n_fail++; $display("FAIL prio_rr[%0d]: got %b expected %b", c, bus.gnt, exp_gnt);
      end
      tick();
    end
    bus.req = '0;
  endtask
`endif

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.enable   = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_alternate();
    test_enable_drop();
    test_reset_midflight();
    test_back_to_back();
`ifdef ARB_PRIO0_EN
    test_prio0();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
